riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, range 1..255: number of cycles mem_req_o stays high without mem_ack_i before the access aborts.
REQ-002 clk  in  1  system clock, all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 core_req_i  in  1  decoder memory_require; load/store requested this cycle.
REQ-005 core_we_i  in  1  1=store, 0=load.
REQ-006 core_size_i  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 core_addr_i  in  32  byte address from ALU result.
REQ-008 core_wd_i  in  32  store data from register file rd2.
REQ-009 core_rd_o  out  32  aligned, extended load data, valid in DONE.
REQ-010 core_stall_o  out  1  holds PC update (feeds the stop signal) while high.
REQ-011 err_o  out  1  access fault: misaligned, illegal size or timeout; valid in DONE.
REQ-012 mem_req_o  out  1  request to data memory, held until ack or timeout.
REQ-013 mem_we_o  out  1  write strobe qualifying mem_req_o.
REQ-014 mem_be_o  out  4  byte lane enables.
REQ-015 mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 mem_wd_o  out  32  lane-replicated store data.
REQ-017 mem_rdata_i  in  32  read word, sampled in the cycle mem_ack_i=1.
REQ-018 mem_ack_i  in  1  completion; ignored unless state=WAIT.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DONE.
REQ-020 IDLE with core_req_i=1 and legal, aligned access SHALL latch we/size/addr/data, drive mem_* registered from next cycle, go to WAIT.
REQ-021 Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or illegal size SHALL go IDLE->DONE with err_o=1, mem_req_o never asserted.
REQ-022 WAIT SHALL hold mem_req_o=1 and all mem_* stable until mem_ack_i=1, then go to DONE with mem_req_o=0 in DONE.
REQ-023 WAIT SHALL count cycles in an 8-bit counter; on reaching TIMEOUT without ack, go to DONE with err_o=1, core_rd_o=0.
REQ-024 Ack in the same cycle the count reaches TIMEOUT SHALL complete normally (ack wins).
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE; err_o SHALL be 1 only in DONE.
REQ-026 core_stall_o SHALL be combinational: (IDLE and core_req_i) or WAIT; 0 in DONE.
REQ-027 Byte lanes: B/BU/SB 4'b0001<<addr[1:0]; H/HU/SH 4'b0011<<{addr[1],1'b0}; W 4'b1111; same mapping for loads.
REQ-028 Store data: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
REQ-029 Load data SHALL be the selected lane shifted to bit 0; B/H sign-extended, BU/HU zero-extended, W unchanged; registered into core_rd_o on ack.
REQ-030 core_req_i deasserting during WAIT SHALL NOT abort the transaction.
REQ-031 Minimum latency: request cycle N, mem_req_o at N+1, ack at N+1, DONE (stall=0, data valid) at N+2.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, counter 0, mem_req_o/mem_we_o/err_o/core_stall_o=0, mem_be_o=0, mem_addr_o/mem_wd_o/core_rd_o=0.
REQ-033 Reset during WAIT SHALL drop mem_req_o asynchronously; a later ack SHALL be ignored.
REQ-034 After release, the first posedge with core_req_i=1 SHALL start a fresh transaction.

Verification
REQ-035 LB at 0x1003, ack in first WAIT cycle, rdata 0x80FF_FFFF -> be=1000, addr 0x1000, core_rd_o=0xFFFF_FF80 at N+2, stall high cycles N..N+1.
REQ-036 SH at 0x2002 with wd 0x1234_ABCD, ack after 3 cycles -> mem_wd_o=0xABCD_ABCD, be=1100, we=1, data stable 3 cycles, stall low in DONE.
REQ-037 LW at 0x0006 -> no mem_req_o, err_o=1 at N+1, core_stall_o high only cycle N.
REQ-038 LHU at 0x0010, TIMEOUT=4, no ack -> mem_req_o high 4 cycles, then DONE err_o=1, core_rd_o=0; ack on the 4th cycle instead -> err_o=0.
REQ-039 LW in WAIT, reset pulsed low, then ack -> mem_req_o=0 immediately, state IDLE, no DONE, core_rd_o=0.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: turns a core load/store request into one data-memory access
// with byte-lane alignment, sign/zero extension, misalignment and timeout faults.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] lane_b, lane_h, load_data;

  // Request decode; stores only accept the signed B/H/W encodings.
  always_comb begin
    req_legal = 1'b0;
    req_be    = 4'b1111;
    req_wd    = core_wd_i;
    case (core_size_i)
      3'b000, 3'b100: req_legal = !(core_we_i && core_size_i[2]);
      3'b001, 3'b101: req_legal = !(core_we_i && core_size_i[2]) && !core_addr_i[0];
      3'b010:         req_legal = (core_addr_i[1:0] == 2'b00);
      default:        req_legal = 1'b0;
    endcase
    case (core_size_i[1:0])
      2'b00: begin
        req_be = 4'b0001 << core_addr_i[1:0];
        req_wd = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        req_be = 4'b0011 << {core_addr_i[1], 1'b0};
        req_wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_wd = core_wd_i;
      end
    endcase
  end

  always_comb begin
    lane_b    = mem_rdata_i >> {addr_q[1:0], 3'b000};
    lane_h    = mem_rdata_i >> {addr_q[1], 4'b0000};
    load_data = mem_rdata_i;
    case (size_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b100:  load_data = {24'd0, lane_b[7:0]};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b101:  load_data = {16'd0, lane_h[15:0]};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          if (req_legal) begin
            we_d    = core_we_i;
            size_d  = core_size_i;
            addr_d  = core_addr_i;
            wd_d    = req_wd;
            be_d    = req_be;
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            rd_d    = 32'd0;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        // Ack is checked first so an ack in the final counted cycle still completes.
        if (mem_ack_i) begin
          rd_d    = we_q ? 32'd0 : load_data;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rd_d    = 32'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o    = (state_q == S_WAIT);
  assign mem_we_o     = mem_req_o && we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wd_o     = wd_q;
  assign core_rd_o    = rd_q;
  assign err_o        = err_q;
  assign core_stall_o = ((state_q == S_IDLE) && core_req_i) || (state_q == S_WAIT);

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed table of spec scenarios, reset-in-WAIT sequence,
// then random transactions checked against an arithmetic reference model.
module tb_riscv_lsu;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rdata_i;
  logic        mem_ack_i;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack;    // WAIT cycle (1-based) carrying the ack, 0 = never
    logic        legal;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdx;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, 0 when the encoding is unusable.
  function automatic int unsigned m_bytes(input logic we, input logic [2:0] size);
    case (size)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return we ? 0 : 1;
      3'd5: return we ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_legal(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int unsigned nb = m_bytes(we, size);
    if (nb == 0) return 1'b0;
    return (addr % nb) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int unsigned nb = m_bytes(we, size);
    int unsigned mask = ((1 << nb) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
    case (m_bytes(1'b1, size))
      1: return 32'(longint'(wd % 256) * 64'h01010101);
      2: return 32'(longint'(wd % 65536) * 64'h00010001);
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] size, input logic [31:0] addr,
                                      input logic [31:0] rdata);
    int unsigned nb = m_bytes(1'b0, size);
    longint v;
    if (nb == 4 || nb == 0) return rdata;
    v = (longint'(rdata) >> (8 * (addr % 4))) % (longint'(1) << (8 * nb));
    if (size < 3'd4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  // One full transaction starting in the current (post-edge) IDLE cycle.
  task automatic do_txn(input string nm, input vec_t v);
    core_req_i  = 1'b1;
    core_we_i   = v.we;
    core_size_i = v.size;
    core_addr_i = v.addr;
    core_wd_i   = v.wd;
    #1;
    chk({nm, " stall_req"}, 32'(core_stall_o), 32'd1);
    tick();
    core_req_i  = 1'b0;
    core_addr_i = $urandom;
    core_wd_i   = $urandom;
    if (v.legal) begin
      for (int k = 1; k <= int'(TO); k++) begin
        chk({nm, " req"}, 32'(mem_req_o), 32'd1);
        chk({nm, " we"}, 32'(mem_we_o), 32'(v.we));
        chk({nm, " be"}, 32'(mem_be_o), 32'(v.be));
        chk({nm, " addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
        if (v.we) chk({nm, " wd"}, mem_wd_o, v.wdx);
        chk({nm, " stall_wait"}, 32'(core_stall_o), 32'd1);
        chk({nm, " err_wait"}, 32'(err_o), 32'd0);
        mem_ack_i   = (k == v.ack);
        mem_rdata_i = (k == v.ack) ? v.rdata : $urandom;
        tick();
        mem_ack_i = 1'b0;
        if (k == v.ack) break;
      end
    end
    chk({nm, " req_done"}, 32'(mem_req_o), 32'd0);
    chk({nm, " stall_done"}, 32'(core_stall_o), 32'd0);
    chk({nm, " err_done"}, 32'(err_o), 32'(v.err));
    chk({nm, " rd_done"}, core_rd_o, v.rd);
    tick();
    chk({nm, " err_idle"}, 32'(err_o), 32'd0);
    chk({nm, " req_idle"}, 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    vec_t r;
    logic [2:0] lsz[8];
    lsz = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    //            we    size  addr          wd            rdata        ack legal err  be       wdx           rd
    tbl[0]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1, 1'b1, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 1'b1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    tbl[2]  = '{1'b0, 3'd2, 32'h0000_0006, 32'h0,        32'h0,         1, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 3'd5, 32'h0000_0010, 32'h0,        32'h1234_5678, 0, 1'b1, 1'b1, 4'b0011, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 3'd5, 32'h0000_0010, 32'h0,        32'h0000_8001, 4, 1'b1, 1'b0, 4'b0011, 32'h0,        32'h0000_8001};
    tbl[5]  = '{1'b0, 3'd4, 32'h0000_1001, 32'h0,        32'h1234_F056, 2, 1'b1, 1'b0, 4'b0010, 32'h0,        32'h0000_00F0};
    tbl[6]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0,        32'h8765_4321, 1, 1'b1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8765};
    tbl[7]  = '{1'b1, 3'd0, 32'h0000_3001, 32'hAABB_CC5A, 32'h0,        1, 1'b1, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    tbl[8]  = '{1'b1, 3'd2, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,        2, 1'b1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,         1, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1, 1'b1, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D};
    tbl[11] = '{1'b1, 3'd1, 32'h0000_0001, 32'h5555_5555, 32'h0,        1, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};

    rst_n = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    #12;
    chk("rst mem_req", 32'(mem_req_o), 32'd0);
    chk("rst mem_we", 32'(mem_we_o), 32'd0);
    chk("rst be", 32'(mem_be_o), 32'd0);
    chk("rst addr", mem_addr_o, 32'd0);
    chk("rst wd", mem_wd_o, 32'd0);
    chk("rst rd", core_rd_o, 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst stall", 32'(core_stall_o), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset pulsed while waiting; a late ack must not produce a DONE.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h0000_0100;
    tick();
    core_req_i = 1'b0;
    chk("rstwait req_before", 32'(mem_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait req_async", 32'(mem_req_o), 32'd0);
    chk("rstwait stall_async", 32'(core_stall_o), 32'd0);
    chk("rstwait rd_async", core_rd_o, 32'd0);
    #2 rst_n = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick();
    mem_ack_i = 1'b0;
    chk("rstwait err_after_ack", 32'(err_o), 32'd0);
    chk("rstwait rd_after_ack", core_rd_o, 32'd0);
    chk("rstwait req_after_ack", 32'(mem_req_o), 32'd0);
    chk("rstwait stall_after_ack", 32'(core_stall_o), 32'd0);
    do_txn("fresh", tbl[10]);

    for (int i = 0; i < 60; i++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.size  = r.we ? ((($urandom % 8) == 0) ? lsz[$urandom_range(3, 7)] : lsz[$urandom_range(0, 2)])
                     : lsz[$urandom_range(0, 7)];
      r.addr  = $urandom;
      if ($urandom_range(0, 2) != 0) r.addr = r.addr & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 2);
      r.wd    = $urandom;
      r.rdata = $urandom;
      r.ack   = int'($urandom_range(0, TO));
      r.legal = m_legal(r.we, r.size, r.addr);
      r.err   = !r.legal || (r.ack == 0);
      r.be    = r.legal ? m_be(r.we, r.size, r.addr) : 4'b0000;
      r.wdx   = m_wd(r.size, r.wd);
      r.rd    = (r.err || r.we) ? 32'd0 : m_rd(r.size, r.addr, r.rdata);
      do_txn($sformatf("rnd%0d", i), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
